// File: rtl/msdap_filter_sequencer_if.sv
// Bundles the sequencer's control, memory-read and result signals.
// The sequencer side uses the slave modport; the controller / memory side
// (sample writer, rj/coeff/data memories, result consumer) uses master.
interface msdap_filter_sequencer_if;
  logic        clear;
  logic        start;
  logic [7:0]  newest_addr;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic [7:0]  read_addr;
  logic [15:0] data_in;
  logic [39:0] y_out;
  logic        y_valid;
  logic        busy;
  logic        overrun;

  modport master (
    output clear, start, newest_addr, rj_data, coeff_data, data_in,
    input  rj_addr, coeff_addr, read_addr, y_out, y_valid, busy, overrun
  );

  modport slave (
    input  clear, start, newest_addr, rj_data, coeff_data, data_in,
    output rj_addr, coeff_addr, read_addr, y_out, y_valid, busy, overrun
  );
endinterface

// File: rtl/msdap_filter_sequencer.sv
// Per-channel MSDAP filter sequencer. For every new sample it walks the 16
// rj group counts, reads one coefficient per cycle, fetches the delayed
// sample from the circular data memory and builds the shift-and-add result:
// each group's partial sum is added to y and the total halved, so group j
// ends up weighted by 2^-(16-j). All memory reads are combinational.
module msdap_filter_sequencer (
  input logic                     clk,
  input logic                     rst_n,
  msdap_filter_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_RJ,
    ACCUM,
    SHIFT,
    DONE
  } seqState_t;

  seqState_t   r_state;
  seqState_t   w_nextState;

  logic [7:0]  r_base;
  logic [3:0]  r_j;
  logic [8:0]  r_c;
  logic [8:0]  r_cnt;
  logic [39:0] r_u;
  logic [39:0] r_y;
  logic [39:0] r_yOut;
  logic        r_yValid;
  logic        r_overrun;

  logic [3:0]  w_rjAddr;
  logic [8:0]  w_coeffAddr;
  logic [7:0]  w_readAddr;
  logic [7:0]  w_tapAddr;
  logic [39:0] w_operand;
  logic [39:0] w_ySum;
  logic [39:0] w_yNext;
  logic        w_unused;

  // Only the low nine rj bits and the low nine coefficient bits carry meaning.
  assign w_unused = ^{bus.rj_data[15:9], bus.coeff_data[15:9]};

  // Delayed sample address wraps naturally in the 256-entry circular buffer.
  assign w_tapAddr = r_base - bus.coeff_data[7:0];

  // Sample is placed in bits [31:16] so the 16 halvings keep its fraction.
  assign w_operand = {{8{bus.data_in[15]}}, bus.data_in, 16'h0000};

  // Group fold: add the partial sum, then arithmetic shift right by one.
  assign w_ySum  = r_y + r_u;
  assign w_yNext = {w_ySum[39], w_ySum[39:1]};

  // State register, cleared asynchronously so a reset aborts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode and memory address generation.
  always_comb begin
    w_nextState = r_state;
    w_rjAddr    = 4'd0;
    w_coeffAddr = 9'd0;
    w_readAddr  = bus.newest_addr;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextState = LOAD_RJ;
        end
      end
      LOAD_RJ: begin
        w_rjAddr    = r_j;
        w_coeffAddr = r_c;
        w_readAddr  = w_tapAddr;
        if (bus.rj_data[8:0] == 9'd0) begin
          w_nextState = SHIFT;
        end else begin
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        w_rjAddr    = r_j;
        w_coeffAddr = r_c;
        w_readAddr  = w_tapAddr;
        if (r_cnt == 9'd1) begin
          w_nextState = SHIFT;
        end
      end
      SHIFT: begin
        w_rjAddr    = r_j;
        w_coeffAddr = r_c;
        w_readAddr  = w_tapAddr;
        if (r_j == 4'd15) begin
          w_nextState = DONE;
        end else begin
          w_nextState = LOAD_RJ;
        end
      end
      DONE: begin
        w_rjAddr    = r_j;
        w_coeffAddr = r_c;
        w_readAddr  = w_tapAddr;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
    if (bus.clear) begin
      w_nextState = IDLE;
    end
  end

  // Counters, accumulators, result register and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= 8'd0;
      r_j       <= 4'd0;
      r_c       <= 9'd0;
      r_cnt     <= 9'd0;
      r_u       <= 40'd0;
      r_y       <= 40'd0;
      r_yOut    <= 40'd0;
      r_yValid  <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.clear) begin
      r_base    <= 8'd0;
      r_j       <= 4'd0;
      r_c       <= 9'd0;
      r_cnt     <= 9'd0;
      r_u       <= 40'd0;
      r_y       <= 40'd0;
      r_yOut    <= 40'd0;
      r_yValid  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_yValid <= 1'b0;
      if (bus.start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_base <= bus.newest_addr;
            r_j    <= 4'd0;
            r_c    <= 9'd0;
            r_u    <= 40'd0;
            r_y    <= 40'd0;
          end
        end
        LOAD_RJ: begin
          r_cnt <= bus.rj_data[8:0];
        end
        ACCUM: begin
          if (bus.coeff_data[8]) begin
            r_u <= r_u - w_operand;
          end else begin
            r_u <= r_u + w_operand;
          end
          r_c   <= r_c + 9'd1;
          r_cnt <= r_cnt - 9'd1;
        end
        SHIFT: begin
          r_y <= w_yNext;
          r_u <= 40'd0;
          if (r_j == 4'd15) begin
            r_yOut   <= w_yNext;
            r_yValid <= 1'b1;
          end else begin
            r_j <= r_j + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Read address is forced to zero while reset is asserted.
  assign bus.read_addr  = rst_n ? w_readAddr : 8'd0;
  assign bus.rj_addr    = w_rjAddr;
  assign bus.coeff_addr = w_coeffAddr;
  assign bus.y_out      = r_yOut;
  assign bus.y_valid    = r_yValid;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overrun    = r_overrun;

endmodule
